dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port word-addressed data memory between the RISC-V core load/store path (port 0) and a secondary master such as a UART loader or debug port (port 1). It registers one request at a time, drives the memory port for exactly one cycle, and returns read data with a one-cycle acknowledge. It sits between the masters and `dmem` and is the only block allowed to drive the memory's `we`/`a`/`wd` inputs.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_pick.sv | 29 ++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    localparam int DMEM_DEPTH_DEFAULT = 64;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selection between the core and aux masters.
// DMEM_ARB_ROUND_ROBIN_EN: on contention, grant the master not served last.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  logic last_i,
`endif
    output logic gnt_valid_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        gnt_id_o    = PORT_CORE;
        if (req0_i && req1_i) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            gnt_id_o = ~last_i;
`else
            gnt_id_o = PORT_CORE;
`endif
        end else if (req1_i) begin
            gnt_id_o = PORT_AUX;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port word-addressed data memory.
// Optional round-robin arbitration via DMEM_ARB_ROUND_ROBIN_EN (default: port 0 fixed priority).
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch the winner's transfer
// ACCESS | memory port driven from latched transfer; read data captured
// RESP   | owner sees ack (in range) or err (out of range) for one cycle
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DMEM_DEPTH_DEFAULT
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              in_range_q, in_range_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic              m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic              m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;
    logic [DATA_W-1:0] acc_rdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    dmem_arb_pick u_pick (
        .req0_i      (m0_req_i),
        .req1_i      (m1_req_i),
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        .last_i      (last_q),
`endif
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign sel_we       = (gnt_id == PORT_AUX) ? m1_we_i    : m0_we_i;
    assign sel_addr     = (gnt_id == PORT_AUX) ? m1_addr_i  : m0_addr_i;
    assign sel_wdata    = (gnt_id == PORT_AUX) ? m1_wdata_i : m0_wdata_i;
    assign sel_in_range = (sel_addr >> 2) < DEPTH_W;
    // Out-of-range accesses return zero rather than whatever the memory aliases to.
    assign acc_rdata    = in_range_q ? mem_rd_i : '0;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        in_range_d = in_range_q;
        mem_we_d   = 1'b0;
        mem_a_d    = mem_a_q;
        mem_wd_d   = mem_wd_q;
        m0_rdata_d = '0;
        m1_rdata_d = '0;
        m0_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m1_err_d   = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d    = gnt_id;
                    in_range_d = sel_in_range;
                    mem_we_d   = sel_we & sel_in_range;
                    mem_a_d    = sel_addr;
                    mem_wd_d   = sel_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    last_d     = gnt_id;
`endif
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (owner_q == PORT_CORE) begin
                    m0_ack_d   = in_range_q;
                    m0_err_d   = ~in_range_q;
                    m0_rdata_d = acc_rdata;
                end else begin
                    m1_ack_d   = in_range_q;
                    m1_err_d   = ~in_range_q;
                    m1_rdata_d = acc_rdata;
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            owner_q    <= PORT_CORE;
            in_range_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q     <= PORT_AUX;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            in_range_q <= in_range_d;
            mem_we_q   <= mem_we_d;
            mem_a_q    <= mem_a_d;
            mem_wd_q   <= mem_wd_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ack_q   <= m0_ack_d;
            m0_err_q   <= m0_err_d;
            m1_ack_q   <= m1_ack_d;
            m1_err_q   <= m1_err_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign mem_we_o   = mem_we_q;
    assign mem_a_o    = mem_a_q;
    assign mem_wd_o   = mem_wd_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;
    assign m0_ack_o   = m0_ack_q;
    assign m0_err_o   = m0_err_q;
    assign m1_ack_o   = m1_ack_q;
    assign m1_err_o   = m1_err_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level memory model.
module tb_dmem_arbiter;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        mem_we, busy;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] ram     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        ram_init = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .mem_we_o(mem_we), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd),
        .busy_o(busy)
    );

    function automatic logic [31:0] seed_word(int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    // Memory writes at its 6-bit index regardless of range, so a stray write aliases visibly.
    assign mem_rd = (mem_a[31:8] == 24'd0) ? ram[mem_a[7:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= seed_word(i);
        end else if (mem_we) begin
            ram[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        vectors++; if (mem_a !== 32'd0) begin miscompares++; $display("FAIL reset_mem_a: got %h expected 0", mem_a); end
        vectors++; if (mem_wd !== 32'd0) begin miscompares++; $display("FAIL reset_mem_wd: got %h expected 0", mem_wd); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
            miscompares++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        vectors++; if ({m0_rdata, m1_rdata} !== 64'd0) begin
            miscompares++; $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata); end
        @(negedge clk) reset_n = 1;
        step();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_write_read();
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        step();
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_mem_we: got %b expected 1", mem_we); end
        vectors++; if (mem_a !== 32'h10) begin miscompares++; $display("FAIL wr_mem_a: got %h expected 00000010", mem_a); end
        vectors++; if (mem_wd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_mem_wd: got %h expected deadbeef", mem_wd); end
        vectors++; if (busy !== 1'b1 || m0_ack !== 1'b0) begin
            miscompares++; $display("FAIL wr_access_state: got busy=%b ack=%b expected busy=1 ack=0", busy, m0_ack); end
        step();
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL wr_resp_mem_we: got %b expected 0", mem_we); end
        vectors++; if (m0_ack !== 1'b1 || m0_err !== 1'b0) begin
            miscompares++; $display("FAIL wr_ack: got ack=%b err=%b expected ack=1 err=0", m0_ack, m0_err); end
        vectors++; if ({m1_ack, m1_err, m1_rdata} !== 34'd0) begin
            miscompares++; $display("FAIL wr_m1_quiet: got ack=%b err=%b rdata=%h expected zeros", m1_ack, m1_err, m1_rdata); end
        m0_req = 0;
        step();
        vectors++; if (m0_ack !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL wr_back_idle: got ack=%b busy=%b expected 0/0", m0_ack, busy); end
        vectors++; if (ram[4] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_mem_content: got %h expected deadbeef", ram[4]); end
        ref_mem[4] = 32'hDEADBEEF;
        m0_req = 1; m0_we = 0;
        step();
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rd_mem_we: got %b expected 0", mem_we); end
        step();
        vectors++; if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL rd_ack: got %b expected 1", m0_ack); end
        vectors++; if (m0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data: got %h expected deadbeef", m0_rdata); end
        vectors++; if ({m1_ack, m1_err, m1_rdata} !== 34'd0) begin
            miscompares++; $display("FAIL rd_m1_quiet: got ack=%b err=%b rdata=%h expected zeros", m1_ack, m1_err, m1_rdata); end
        m0_req = 0;
        step();
    endtask

    task automatic test_out_of_range();
        logic we_seen;
        we_seen = 0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h100; m1_wdata = 32'h1234_5678;
        step();
        we_seen |= mem_we;
        step();
        we_seen |= mem_we;
        vectors++; if (m1_err !== 1'b1 || m1_ack !== 1'b0) begin
            miscompares++; $display("FAIL oor_wr_err: got err=%b ack=%b expected err=1 ack=0", m1_err, m1_ack); end
        vectors++; if (m1_rdata !== 32'd0) begin miscompares++; $display("FAIL oor_wr_rdata: got %h expected 0", m1_rdata); end
        vectors++; if ({m0_ack, m0_err, m0_rdata} !== 34'd0) begin
            miscompares++; $display("FAIL oor_m0_quiet: got ack=%b err=%b rdata=%h expected zeros", m0_ack, m0_err, m0_rdata); end
        m1_req = 0;
        step();
        we_seen |= mem_we;
        vectors++; if (we_seen !== 1'b0) begin miscompares++; $display("FAIL oor_no_write: got mem_we pulse=%b expected 0", we_seen); end
        vectors++; if (m1_err !== 1'b0) begin miscompares++; $display("FAIL oor_err_pulse: got %b expected 0", m1_err); end
        vectors++; if (ram[0] !== ref_mem[0]) begin miscompares++; $display("FAIL oor_mem_intact: got %h expected %h", ram[0], ref_mem[0]); end
        m0_req = 1; m0_we = 0; m0_addr = 32'hFFFF_FFFC;
        step(); step();
        vectors++; if (m0_err !== 1'b1 || m0_ack !== 1'b0 || m0_rdata !== 32'd0) begin
            miscompares++; $display("FAIL oor_rd: got err=%b ack=%b rdata=%h expected 1/0/0", m0_err, m0_ack, m0_rdata); end
        m0_req = 0;
        step();
    endtask

    task automatic test_reset_mid();
        m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hCAFE_F00D;
        step();
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL rmid_access: got mem_we=%b expected 1", mem_we); end
        #2 reset_n = 0;
        #1;
        vectors++; if (mem_we !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rmid_async: got mem_we=%b busy=%b expected 0/0", mem_we, busy); end
        m0_req = 0;
        step();
        vectors++; if ({m0_ack, m0_err} !== 2'b0) begin miscompares++; $display("FAIL rmid_no_ack: got %b expected 00", {m0_ack, m0_err}); end
        @(negedge clk) reset_n = 1;
        vectors++; if (ram[8] !== ref_mem[8]) begin miscompares++; $display("FAIL rmid_no_write: got %h expected %h", ram[8], ref_mem[8]); end
        step();
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        step(); step();
        vectors++; if (m0_ack !== 1'b1 || m0_rdata !== ref_mem[8]) begin
            miscompares++; $display("FAIL rmid_after: got ack=%b rdata=%h expected 1/%h", m0_ack, m0_rdata, ref_mem[8]); end
        m0_req = 0;
        step();
    endtask

    task automatic test_hold_req();
        logic [4:0] exp_ack;
        logic [4:0] exp_busy;
        exp_ack  = 5'b10010;
        exp_busy = 5'b11011;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        for (int k = 0; k < 5; k++) begin
            step();
            vectors++; if (m0_ack !== exp_ack[k] || busy !== exp_busy[k]) begin
                miscompares++;
                $display("FAIL hold_seq[%0d]: got ack=%b busy=%b expected ack=%b busy=%b", k, m0_ack, busy, exp_ack[k], exp_busy[k]);
            end
            if (exp_ack[k]) begin
                vectors++; if (m0_rdata !== ref_mem[4]) begin
                    miscompares++; $display("FAIL hold_rdata[%0d]: got %h expected %h", k, m0_rdata, ref_mem[4]); end
            end
        end
        m0_req = 0;
        step(); step();
    endtask

    task automatic test_contention();
        int exp_port [4];
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_port = '{0, 1, 0, 1};
`else
        exp_port = '{0, 0, 0, 0};
`endif
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h4;
        for (int k = 0; k < 12; k++) begin
            logic e0, e1;
            step();
            e0 = (k % 3 == 1) && (exp_port[k / 3] == 0);
            e1 = (k % 3 == 1) && (exp_port[k / 3] == 1);
            vectors++; if (m0_ack !== e0 || m1_ack !== e1) begin
                miscompares++; $display("FAIL contend_grant[%0d]: got ack0=%b ack1=%b expected %b/%b", k, m0_ack, m1_ack, e0, e1); end
            if (e0) begin
                vectors++; if (m0_rdata !== ref_mem[0]) begin
                    miscompares++; $display("FAIL contend_rdata0[%0d]: got %h expected %h", k, m0_rdata, ref_mem[0]); end
            end
            if (e1) begin
                vectors++; if (m1_rdata !== ref_mem[1]) begin
                    miscompares++; $display("FAIL contend_rdata1[%0d]: got %h expected %h", k, m1_rdata, ref_mem[1]); end
            end
        end
        idle_inputs();
        repeat (3) step();
    endtask

    task automatic test_random();
        logic        pend [2];
        logic        twe  [2];
        logic [31:0] taddr[2];
        logic [31:0] twd  [2];
        int          gap  [2];
        int          waitc[2];
        int          limit[2];
        logic        ack, err;
        logic [31:0] rd;
        int unsigned word;
        logic        exp_err;
        logic        done [2];
        limit[0] = 6;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        limit[1] = 6;
`else
        limit[1] = 90;
`endif
        for (int p = 0; p < 2; p++) begin pend[p] = 0; gap[p] = 0; waitc[p] = 0; end
        for (int c = 0; c < 600; c++) begin
            if (c >= 500 && !pend[0] && !pend[1]) break;
            step();
            for (int p = 0; p < 2; p++) begin
                ack = (p == 0) ? m0_ack : m1_ack;
                err = (p == 0) ? m0_err : m1_err;
                rd  = (p == 0) ? m0_rdata : m1_rdata;
                done[p] = ack | err;
                if (ack | err) begin
                    vectors++;
                    if (!pend[p]) begin
                        miscompares++; $display("FAIL rnd_spurious[%0d]: got ack=%b err=%b expected none at cycle %0d", p, ack, err, c);
                    end else begin
                        word = taddr[p] >> 2;
                        exp_err = (word >= DEPTH);
                        if (err !== exp_err || ack !== !exp_err) begin
                            miscompares++; $display("FAIL rnd_status[%0d]: got ack=%b err=%b expected err=%b addr=%h", p, ack, err, exp_err, taddr[p]);
                        end
                        if (exp_err) begin
                            vectors++; if (rd !== 32'd0) begin
                                miscompares++; $display("FAIL rnd_err_rdata[%0d]: got %h expected 0", p, rd); end
                        end else if (!twe[p]) begin
                            vectors++; if (rd !== ref_mem[word]) begin
                                miscompares++; $display("FAIL rnd_rdata[%0d]: got %h expected %h addr=%h", p, rd, ref_mem[word], taddr[p]); end
                        end else begin
                            ref_mem[word] = twd[p];
                        end
                        pend[p] = 0;
                        gap[p] = int'($urandom_range(0, 2));
                        waitc[p] = 0;
                    end
                end else if (pend[p]) begin
                    waitc[p]++;
                    if (waitc[p] == limit[p] + 1) begin
                        vectors++; miscompares++;
                        $display("FAIL rnd_timeout[%0d]: got no completion after %0d cycles expected within %0d", p, waitc[p], limit[p]);
                    end
                end
            end
            vectors++; if (done[0] && done[1]) begin
                miscompares++; $display("FAIL rnd_dual_complete: got both ports completing at cycle %0d expected one", c); end
            vectors++; if (mem_we && (!busy || mem_a[31:8] != 24'd0)) begin
                miscompares++; $display("FAIL rnd_mem_we: got mem_we=1 busy=%b addr=%h expected in-range access", busy, mem_a); end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && c < 500) begin
                    if (gap[p] == 0) begin
                        pend[p]  = 1;
                        twe[p]   = 1'($urandom_range(0, 1));
                        taddr[p] = ($urandom_range(0, 71) << 2) | $urandom_range(0, 3);
                        twd[p]   = $urandom;
                    end else begin
                        gap[p]--;
                    end
                end
            end
            m0_req = pend[0]; m0_we = twe[0]; m0_addr = taddr[0]; m0_wdata = twd[0];
            m1_req = pend[1]; m1_we = twe[1]; m1_addr = taddr[1]; m1_wdata = twd[1];
        end
        idle_inputs();
        vectors++; if (pend[0] || pend[1]) begin
            miscompares++; $display("FAIL rnd_drain: got pending %b%b expected 00", pend[1], pend[0]); end
        repeat (3) step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by 300us expected earlier finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        idle_inputs();
        @(posedge clk);
        @(negedge clk) ram_init = 0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_reset_mid();
        test_hold_req();
        test_contention();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
